zigzag_dequant: RTL

//  Upstream neighbour of the IDCT stage. Takes entropy-decoded coefficients one per

---
 rtl/zigzag_dequant.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/zigzag_dequant.sv
// zigzag_dequant: dequantizes zigzag-ordered coefficients against a loadable
// quant table, saturates them to OUT_W signed bits, scatters them into raster
// order and emits each finished 8x8 block as one wide word for the IDCT.
module zigzag_dequant #(
  parameter int COEF_W = 12,
  parameter int QT_W   = 8,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [COEF_W-1:0]     s_data,
  input  logic                  s_last,
  input  logic                  qt_we,
  input  logic [5:0]            qt_addr,
  input  logic [QT_W-1:0]       qt_data,
  output logic [64*OUT_W-1:0]   data_out,
  output logic                  m_valid
);

  // Product width: signed coefficient times zero-extended quant value.
  localparam int PW = COEF_W + QT_W + 1;
  localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]             state_r;
  logic [5:0]             idx_r;
  logic [QT_W-1:0]        qt_r [64];
  logic [64*OUT_W-1:0]    buf_r;
  logic [64*OUT_W-1:0]    buf_next_s;
  logic [64*OUT_W-1:0]    data_out_r;
  logic                   m_valid_r;
  logic                   s_ready_s;
  logic                   beat_s;
  logic                   final_s;
  logic signed [PW-1:0]   prod_s;
  logic signed [OUT_W-1:0] sat_s;
  logic [5:0]             raster_s;

  // Fixed JPEG zigzag scan: zigzag index -> raster position (row*8+col).
  function automatic logic [5:0] zz2raster(input logic [5:0] zz);
    logic [5:0] r;
    case (zz)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = zz;
    endcase
    return r;
  endfunction

  // Clamp a full-precision product into the signed output range.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [PW-1:0] p);
    logic signed [OUT_W-1:0] v;
    if (p > SAT_MAX) begin
      v = SAT_MAX[OUT_W-1:0];
    end else if (p < SAT_MIN) begin
      v = SAT_MIN[OUT_W-1:0];
    end else begin
      v = p[OUT_W-1:0];
    end
    return v;
  endfunction

  // Upstream may only hand over coefficients while filling and out of reset.
  assign s_ready_s = ~rst & (state_r == ST_FILL);
  assign beat_s    = s_valid & s_ready_s;
  assign final_s   = beat_s & ((idx_r == 6'd63) | s_last);
  assign raster_s  = zz2raster(idx_r);
  assign prod_s    = $signed(s_data) * $signed({1'b0, qt_r[idx_r]});
  assign sat_s     = saturate(prod_s);

  // Work buffer with the current beat merged in at its raster position.
  always_comb begin
    buf_next_s = buf_r;
    if (beat_s) begin
      buf_next_s[raster_s*OUT_W +: OUT_W] = sat_s;
    end else begin
      buf_next_s = buf_r;
    end
  end

  // Quant table: reset to unity; writes land the following cycle, so a beat
  // in the same cycle still reads the previous entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        qt_r[i] <= QT_W'(1);
      end
    end else if (qt_we) begin
      qt_r[qt_addr] <= qt_data;
    end
  end

  // Block assembly: fill on beats, publish the finished block on the final
  // beat so m_valid is visible during the single FLUSH cycle, then clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FILL;
      idx_r      <= 6'd0;
      buf_r      <= '0;
      data_out_r <= '0;
      m_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          m_valid_r <= final_s;
          if (beat_s) begin
            buf_r <= buf_next_s;
            if (final_s) begin
              state_r    <= ST_FLUSH;
              idx_r      <= 6'd0;
              data_out_r <= buf_next_s;
            end else begin
              idx_r <= idx_r + 6'd1;
            end
          end
        end
        ST_FLUSH: begin
          m_valid_r <= 1'b0;
          buf_r     <= '0;
          state_r   <= ST_FILL;
        end
        default: begin
          m_valid_r <= 1'b0;
          buf_r     <= '0;
          idx_r     <= 6'd0;
          state_r   <= ST_FILL;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_s;
  assign data_out = data_out_r;
  assign m_valid  = m_valid_r;

endmodule
